// File: rtl/split_gen_pkg.sv
// Shared types and constants for the split_* stimulus generator:
// FSM state encoding, default LFSR seed, Galois tap masks and chunk math.
package split_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_CHECK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAIL  = 3'd4
  } gen_state_e;

  localparam logic [31:0] DEF_SEED = 32'hACE1_2468;

  // Right-shifting Galois masks for maximal-length polynomials.
  localparam logic [63:0] TAPS_8  = 64'h0000_0000_0000_00B8; // x^8+x^6+x^5+x^4+1
  localparam logic [63:0] TAPS_16 = 64'h0000_0000_0000_B400; // x^16+x^14+x^13+x^11+1
  localparam logic [63:0] TAPS_24 = 64'h0000_0000_00E1_0000; // x^24+x^23+x^22+x^17+1
  localparam logic [63:0] TAPS_32 = 64'h0000_0000_8020_0003; // x^32+x^22+x^2+x+1
  localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000; // x^64+x^63+x^61+x^60+1

  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      8:       return TAPS_8;
      16:      return TAPS_16;
      24:      return TAPS_24;
      64:      return TAPS_64;
      default: return TAPS_32;
    endcase
  endfunction

  // Number of GEN cycles needed to fill a vec_w-bit vector.
  function automatic int calc_chunks(input int vec_w, input int chunk_w);
    return (vec_w + chunk_w - 1) / chunk_w;
  endfunction

endpackage

// File: rtl/split_stim_gen_if.sv
// Checker-side and downstream-side signals of the stimulus generator.
// Handshake: a vector transfers on any clock edge where out_valid and
// out_ready are both high; once raised, out_valid and out_vec hold
// unchanged until that transfer, and out_ready may toggle freely.
interface split_stim_gen_if #(
  parameter int VEC_W = 64
) ();

  logic [VEC_W-1:0] chk_vec;
  logic             chk_x;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] out_vec;

  modport master (
    output chk_vec,
    input  chk_x,
    output out_valid,
    input  out_ready,
    output out_vec
  );

  modport slave (
    input  chk_vec,
    output chk_x,
    input  out_valid,
    output out_ready,
    input  out_vec
  );

endinterface

// File: rtl/split_stim_gen_lfsr.sv
// Galois LFSR advanced STEPS positions per enabled cycle. The state can
// never become zero: both reset and a zero load fall back to SEED.
module lfsr_multistep #(
  parameter int             W     = 32,
  parameter int             STEPS = 32,
  parameter logic [W-1:0]   SEED  = 32'hACE1_2468,
  parameter logic [W-1:0]   TAPS  = 32'h8020_0003
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         adv,
  output logic [W-1:0] q
);

  logic [W-1:0] nxt;

  // Unrolled STEPS single-bit Galois shifts.
  always_comb begin
    nxt = q;
    for (int i = 0; i < STEPS; i++) begin
      nxt = {1'b0, nxt[W-1:1]} ^ (nxt[0] ? TAPS : '0);
    end
  end

  // State register: load wins over advance; zero seed maps to SEED.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (load) begin
      q <= (load_val == '0) ? SEED : load_val;
    end else if (adv) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/split_stim_gen.sv
// Stimulus source for split_* constraint checkers: fills chk_vec from an
// LFSR in CHUNK_W slices, samples the checker verdict, and forwards only
// satisfying vectors downstream over valid/ready.
module split_stim_gen #(
  parameter int                VEC_W     = 64,
  parameter int                CHUNK_W   = 32,
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] DEF_SEED  = LFSR_W'(split_gen_pkg::DEF_SEED),
  parameter int                MAX_TRIES = 1024,
  localparam int               TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     seed_load,
  input  logic [LFSR_W-1:0]        seed_in,
  split_stim_gen_if.master         bus,
  output logic                     busy,
  output logic                     fail,
  output logic [TRY_W-1:0]         try_cnt,
  output logic [31:0]              acc_cnt,
  output split_gen_pkg::gen_state_e state_dbg
);

  import split_gen_pkg::*;

  localparam int CHUNKS = calc_chunks(VEC_W, CHUNK_W);
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int EXT_W  = CHUNKS * CHUNK_W;

  gen_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [EXT_W-1:0]        vec_q;
  logic                    out_valid_q;
  logic                    fail_q;
  logic [TRY_W-1:0]        try_q;
  logic [31:0]             acc_q;
  logic [LFSR_W-1:0]       lfsr_q;

  logic chunk_last;
  logic gen_chunk;
  logic accept;
  logic reject;
  logic handshake;
  logic lfsr_load;
  logic enter_fail;

  assign chunk_last = (idx_q == IDX_W'(CHUNKS - 1));

  lfsr_multistep #(
    .W     (LFSR_W),
    .STEPS (CHUNK_W),
    .SEED  (DEF_SEED),
    .TAPS  (LFSR_W'(lfsr_taps(LFSR_W)))
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed_in),
    .adv      (gen_chunk),
    .q        (lfsr_q)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control strobes. The handshake cycle in HOLD
  // also writes chunk 0 of the next vector so back-to-back vectors take
  // CHUNKS+1 cycles each.
  always_comb begin
    state_d    = state_q;
    gen_chunk  = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    handshake  = 1'b0;
    lfsr_load  = 1'b0;
    enter_fail = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lfsr_load = seed_load;
        if (run) state_d = ST_GEN;
      end
      ST_GEN: begin
        gen_chunk = 1'b1;
        if (chunk_last) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (bus.chk_x) begin
          accept  = 1'b1;
          state_d = ST_HOLD;
        end else begin
          reject = 1'b1;
          // The incremented count reaching MAX_TRIES ends generation.
          if (try_q == TRY_W'(MAX_TRIES - 1)) begin
            enter_fail = 1'b1;
            state_d    = ST_FAIL;
          end else if (run) begin
            state_d = ST_GEN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          handshake = 1'b1;
          if (run) begin
            gen_chunk = 1'b1;
            state_d   = chunk_last ? ST_CHECK : ST_GEN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Vector assembly, handshake flag, sticky fail and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      fail_q      <= 1'b0;
      try_q       <= '0;
      acc_q       <= '0;
    end else begin
      if (gen_chunk) begin
        vec_q[idx_q*CHUNK_W +: CHUNK_W] <= lfsr_q[CHUNK_W-1:0];
        idx_q <= chunk_last ? '0 : idx_q + IDX_W'(1);
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        try_q       <= '0;
      end
      if (reject) begin
        try_q <= try_q + TRY_W'(1);
      end
      if (handshake) begin
        out_valid_q <= 1'b0;
        acc_q       <= acc_q + 32'd1;
      end
      if (enter_fail) begin
        fail_q <= 1'b1;
      end
    end
  end

  assign bus.chk_vec   = vec_q[VEC_W-1:0];
  assign bus.out_vec   = vec_q[VEC_W-1:0];
  assign bus.out_valid = out_valid_q;
  assign busy          = (state_q != ST_IDLE);
  assign fail          = fail_q;
  assign try_cnt       = try_q;
  assign acc_cnt       = acc_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_split_stim_gen.sv
// Directed bench for split_stim_gen with a 64-bit vector built from two
// 32-bit chunks and MAX_TRIES=4. The checker verdict is driven directly.
module tb_split_stim_gen;
  import split_gen_pkg::*;

  localparam int          VEC_W     = 64;
  localparam int          CHUNK_W   = 32;
  localparam int          LFSR_W    = 32;
  localparam int          MAX_TRIES = 4;
  localparam int          TRY_W     = 3;
  localparam logic [31:0] SEED0     = 32'hACE1_2468;
  localparam logic [31:0] POLY      = 32'h8020_0003;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              run = 1'b0;
  logic              seed_load = 1'b0;
  logic [31:0]       seed_in = '0;
  logic              busy;
  logic              fail;
  logic [TRY_W-1:0]  try_cnt;
  logic [31:0]       acc_cnt;
  gen_state_e        state_dbg;

  split_stim_gen_if #(.VEC_W(VEC_W)) bus ();

  split_stim_gen #(
    .VEC_W     (VEC_W),
    .CHUNK_W   (CHUNK_W),
    .LFSR_W    (LFSR_W),
    .DEF_SEED  (SEED0),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .bus       (bus.master),
    .busy      (busy),
    .fail      (fail),
    .try_cnt   (try_cnt),
    .acc_cnt   (acc_cnt),
    .state_dbg (state_dbg)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // reference model: bit-serial right-shift Galois LFSR
  function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      if (s[0]) s = (s >> 1) ^ POLY;
      else      s = s >> 1;
    end
    return s;
  endfunction

  // k-th generated vector from seed s: low chunk is the current state,
  // high chunk the state 32 steps later; each vector consumes 64 steps.
  function automatic logic [63:0] model_vec(input logic [31:0] s, input int k);
    logic [31:0] t;
    t = lfsr_adv(s, 64 * k);
    return {lfsr_adv(t, 32), t};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    run           = 1'b0;
    seed_load     = 1'b0;
    bus.chk_x     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_in   = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  // Wait (bounded) for out_valid; a timeout is a failed comparison.
  task automatic get_vec(input string name, output logic [63:0] v);
    bit got;
    got = 0;
    v   = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.out_valid) begin
        got = 1;
        v   = bus.chk_vec;
      end
    end
    chk_cnt++;
    if (!got) $display("FAIL %s_timeout: out_valid=0 after 20 cycles, required 1", name);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (bus.chk_vec !== 64'h0) $display("FAIL rst_chk_vec: got %h want 0", bus.chk_vec); else pass_cnt++;
    chk_cnt++; if (acc_cnt !== 32'd0) $display("FAIL rst_acc: got %0d want 0", acc_cnt); else pass_cnt++;
    chk_cnt++; if (fail !== 1'b0) $display("FAIL rst_fail: got %b want 0", fail); else pass_cnt++;
    chk_cnt++; if (try_cnt !== 3'd0) $display("FAIL rst_try: got %0d want 0", try_cnt); else pass_cnt++;
    tick();
    tick();
    chk_cnt++; if (state_dbg !== ST_IDLE) $display("FAIL idle_state: got %0d want %0d", state_dbg, ST_IDLE); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  // Always-true checker, out_ready high: run edge is edge 0, vectors
  // present at edges 3,6,...,30 and hand off one edge later.
  task automatic test_accept();
    int  vidx;
    logic exp_v;
    do_reset();
    bus.chk_x     = 1'b1;
    bus.out_ready = 1'b1;
    run           = 1'b1;
    vidx          = 0;
    for (int e = 0; e <= 30; e++) begin
      tick();
      exp_v = (e >= 3) && (e % 3 == 0);
      chk_cnt++;
      if (bus.out_valid !== exp_v) $display("FAIL acc_valid_e%0d: got %b want %b", e, bus.out_valid, exp_v);
      else pass_cnt++;
      if (exp_v) begin
        chk_cnt++;
        if (bus.chk_vec !== model_vec(SEED0, vidx))
          $display("FAIL acc_vec%0d: got %h want %h", vidx, bus.chk_vec, model_vec(SEED0, vidx));
        else pass_cnt++;
        vidx++;
      end
    end
    tick(); // edge 31: tenth handshake
    chk_cnt++; if (acc_cnt !== 32'd10) $display("FAIL acc_cnt_10: got %0d want 10", acc_cnt); else pass_cnt++;
    // run falls mid-vector: vector finishes, is accepted, then IDLE
    run = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL acc_stop_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (acc_cnt !== 32'd11) $display("FAIL acc_stop_cnt: got %0d want 11", acc_cnt); else pass_cnt++;
  endtask

  // Always-false checker: rejections at edges 3,6,9,12; fail at edge 12.
  task automatic test_fail();
    bit seen_valid;
    do_reset();
    bus.chk_x     = 1'b0;
    bus.out_ready = 1'b1;
    run           = 1'b1;
    seen_valid    = 0;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (bus.out_valid) seen_valid = 1;
      if (e == 3) begin
        chk_cnt++; if (try_cnt !== 3'd1) $display("FAIL fail_try1: got %0d want 1", try_cnt); else pass_cnt++;
      end
      if (e == 11) begin
        chk_cnt++; if (fail !== 1'b0) $display("FAIL fail_early: got %b want 0 at edge 11", fail); else pass_cnt++;
      end
    end
    chk_cnt++; if (fail !== 1'b1) $display("FAIL fail_set: got %b want 1 at edge 12", fail); else pass_cnt++;
    chk_cnt++; if (state_dbg !== ST_FAIL) $display("FAIL fail_state: got %0d want %0d", state_dbg, ST_FAIL); else pass_cnt++;
    chk_cnt++; if (try_cnt !== 3'd4) $display("FAIL fail_try4: got %0d want 4", try_cnt); else pass_cnt++;
    chk_cnt++; if (seen_valid !== 1'b0) $display("FAIL fail_no_valid: got %b want 0", seen_valid); else pass_cnt++;
    run = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_cnt++; if (fail !== 1'b1 || busy !== 1'b1) $display("FAIL fail_sticky: fail=%b busy=%b want 1/1", fail, busy); else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL fail_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    do_reset();
    chk_cnt++; if (fail !== 1'b0) $display("FAIL fail_clear: got %b want 0", fail); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    logic [31:0] a0;
    do_reset();
    bus.chk_x     = 1'b1;
    bus.out_ready = 1'b0;
    run           = 1'b1;
    get_vec("bp", held);
    a0 = acc_cnt;
    chk_cnt++; if (held !== model_vec(SEED0, 0)) $display("FAIL bp_vec: got %h want %h", held, model_vec(SEED0, 0)); else pass_cnt++;
    run = 1'b0; // must not drop out_valid
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b want 1", i, bus.out_valid); else pass_cnt++;
      chk_cnt++; if (bus.out_vec !== held) $display("FAIL bp_stable%0d: got %h want %h", i, bus.out_vec, held); else pass_cnt++;
      chk_cnt++; if (acc_cnt !== a0) $display("FAIL bp_acc%0d: got %0d want %0d", i, acc_cnt, a0); else pass_cnt++;
    end
    bus.out_ready = 1'b1;
    tick();
    chk_cnt++; if (acc_cnt !== a0 + 32'd1) $display("FAIL bp_handshake: got %0d want %0d", acc_cnt, a0 + 32'd1); else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (state_dbg !== ST_IDLE) $display("FAIL bp_idle: got %0d want %0d", state_dbg, ST_IDLE); else pass_cnt++;
  endtask

  task automatic test_seed();
    logic [63:0] v0, v1, a0, a1, b0, b1;
    // zero seed after a non-default seed must restore DEF_SEED
    do_reset();
    load_seed(32'h1);
    load_seed(32'h0);
    bus.chk_x     = 1'b1;
    bus.out_ready = 1'b1;
    run           = 1'b1;
    get_vec("seed0_a", v0);
    get_vec("seed0_b", v1);
    chk_cnt++; if (v0 !== model_vec(SEED0, 0)) $display("FAIL seed0_v0: got %h want %h", v0, model_vec(SEED0, 0)); else pass_cnt++;
    chk_cnt++; if (v1 !== model_vec(SEED0, 1)) $display("FAIL seed0_v1: got %h want %h", v1, model_vec(SEED0, 1)); else pass_cnt++;
    // seed 1, first pass
    do_reset();
    load_seed(32'h1);
    bus.chk_x     = 1'b1;
    bus.out_ready = 1'b1;
    run           = 1'b1;
    get_vec("seed1_a0", a0);
    get_vec("seed1_a1", a1);
    chk_cnt++; if (a0[31:0] !== 32'h1) $display("FAIL seed1_chunk0: got %h want 00000001", a0[31:0]); else pass_cnt++;
    chk_cnt++; if (a0 !== model_vec(32'h1, 0)) $display("FAIL seed1_v0: got %h want %h", a0, model_vec(32'h1, 0)); else pass_cnt++;
    // seed 1, second pass, with a seed_load attempt while busy
    do_reset();
    load_seed(32'h1);
    bus.chk_x     = 1'b1;
    bus.out_ready = 1'b1;
    run           = 1'b1;
    tick();
    seed_in   = 32'hDEAD_BEEF;
    seed_load = 1'b1;
    get_vec("seed1_b0", b0);
    seed_load = 1'b0;
    get_vec("seed1_b1", b1);
    chk_cnt++; if (b0 !== a0) $display("FAIL seed1_rep0: got %h want %h", b0, a0); else pass_cnt++;
    chk_cnt++; if (b1 !== a1) $display("FAIL seed1_rep1: got %h want %h", b1, a1); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] v;
    // mid-GEN
    do_reset();
    bus.chk_x     = 1'b1;
    bus.out_ready = 1'b1;
    run           = 1'b1;
    tick();
    tick();
    chk_cnt++; if (bus.chk_vec === 64'h0) $display("FAIL rg_chunk0: got %h want nonzero", bus.chk_vec); else pass_cnt++;
    rst = 1'b1;
    tick();
    chk_cnt++; if (state_dbg !== ST_IDLE) $display("FAIL rg_state: got %0d want %0d", state_dbg, ST_IDLE); else pass_cnt++;
    chk_cnt++; if (bus.chk_vec !== 64'h0) $display("FAIL rg_vec: got %h want 0", bus.chk_vec); else pass_cnt++;
    rst = 1'b0;
    get_vec("rg", v);
    chk_cnt++; if (v !== model_vec(SEED0, 0)) $display("FAIL rg_lfsr: got %h want %h", v, model_vec(SEED0, 0)); else pass_cnt++;
    // mid-HOLD, after one completed handshake
    do_reset();
    bus.chk_x     = 1'b1;
    bus.out_ready = 1'b1;
    run           = 1'b1;
    get_vec("rh_a", v);
    tick();
    bus.out_ready = 1'b0;
    get_vec("rh_b", v);
    chk_cnt++; if (acc_cnt !== 32'd1) $display("FAIL rh_pre_acc: got %0d want 1", acc_cnt); else pass_cnt++;
    rst = 1'b1;
    run = 1'b0;
    tick();
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rh_valid: got %b want 0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (acc_cnt !== 32'd0) $display("FAIL rh_acc: got %0d want 0", acc_cnt); else pass_cnt++;
    chk_cnt++; if (state_dbg !== ST_IDLE) $display("FAIL rh_state: got %0d want %0d", state_dbg, ST_IDLE); else pass_cnt++;
    rst           = 1'b0;
    run           = 1'b1;
    bus.out_ready = 1'b1;
    get_vec("rh_c", v);
    chk_cnt++; if (v !== model_vec(SEED0, 0)) $display("FAIL rh_lfsr: got %h want %h", v, model_vec(SEED0, 0)); else pass_cnt++;
  endtask

  initial begin
    bus.chk_x     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_accept();
    test_fail();
    test_backpressure();
    test_seed();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
